// File: rtl/register_file.sv
// Integer register file for the RV32I core: NUM_REGISTER x DATA_WIDTH storage,
// two combinational read ports and one write port that updates on the rising clock edge.
// Register x0 always reads zero.
//
// Ports:
//   clk_i       rising-edge clock for the write port
//   rst_i       asynchronous active-high reset; clears every register
//   we_i        write enable for the rd port
//   rd_addr_i   destination register address
//   rd_i        write data
//   rs1_addr_i  read port 1 address
//   rs2_addr_i  read port 2 address
//   rs1_o       read port 1 data (combinational)
//   rs2_o       read port 2 data (combinational)
module register_file #(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned NUM_REGISTER = 32,
    localparam int unsigned AW           = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_i,
    input  logic [AW-1:0]         rs1_addr_i,
    input  logic [AW-1:0]         rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_o,
    output logic [DATA_WIDTH-1:0] rs2_o
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGISTER];
    logic                  w_wr_en;

    // Writes to x0 are dropped here, so entry 0 keeps its reset value of zero.
    assign w_wr_en = we_i && (rd_addr_i != '0);

    // Storage: async clear, single write per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGISTER); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd_addr_i] <= rd_i;
        end
    end

    // Read ports: no write-to-read forwarding; x0 forced to zero explicitly.
    always_comb begin
        rs1_o = '0;
        rs2_o = '0;
        if (rs1_addr_i != '0) begin
            rs1_o = r_regs[rs1_addr_i];
        end
        if (rs2_addr_i != '0) begin
            rs2_o = r_regs[rs2_addr_i];
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          we_i;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_i;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic [DW-1:0] rs1_o;
    logic [DW-1:0] rs2_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Architectural view of the register file.
    logic [DW-1:0] model [NR];

    register_file #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (we_i),
        .rd_addr_i  (rd_addr_i),
        .rd_i       (rd_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset wipes everything immediately; a write lands on the clock edge.
    always @(posedge rst_i) begin
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NR); i++) model[i] = '0;
        end else if (we_i === 1'b1 && rd_addr_i != '0) begin
            model[rd_addr_i] = rd_i;
        end
    end

    // Compare process: read ports against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("rs1_model", rs1_o, (rs1_addr_i == '0) ? '0 : model[rs1_addr_i]);
            check("rs2_model", rs2_o, (rs2_addr_i == '0) ? '0 : model[rs2_addr_i]);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
        rst_i      = 1'b1;
        we_i       = 1'b0;
        rd_addr_i  = '0;
        rd_i       = '0;
        rs1_addr_i = '0;
        rs2_addr_i = '0;

        // Reset state
        tick();
        tick();
        check("reset_rs1", rs1_o, 32'h0);
        check("reset_rs2", rs2_o, 32'h0);
        rst_i = 1'b0;
        tick();
        check("post_reset_rs1", rs1_o, 32'h0);
        check("post_reset_rs2", rs2_o, 32'h0);
        chk_en = 1'b1;

        // Write x1 = 1
        we_i = 1'b1; rd_addr_i = 5'd1; rd_i = 32'h0000_0001;
        tick();
        we_i = 1'b0; rs1_addr_i = 5'd1; rs2_addr_i = 5'd2;
        #1;
        check("write1_rs1", rs1_o, 32'h0000_0001);
        check("write1_rs2", rs2_o, 32'h0000_0000);

        // Same-cycle read/write of x1: old value until the edge
        we_i = 1'b1; rd_addr_i = 5'd1; rd_i = 32'h5555_AAAA;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd1;
        #1;
        check("no_fwd_rs1", rs1_o, 32'h0000_0001);
        check("no_fwd_rs2", rs2_o, 32'h0000_0001);
        tick();
        we_i = 1'b0;
        check("after_edge_rs1", rs1_o, 32'h5555_AAAA);
        check("after_edge_rs2", rs2_o, 32'h5555_AAAA);

        // Top register
        we_i = 1'b1; rd_addr_i = 5'd31; rd_i = 32'hFFFF_FFFF;
        tick();
        we_i = 1'b0; rs1_addr_i = 5'd31; rs2_addr_i = 5'd0;
        #1;
        check("top_rs1", rs1_o, 32'hFFFF_FFFF);
        check("top_rs2", rs2_o, 32'h0);

        // x0 protection
        we_i = 1'b1; rd_addr_i = 5'd0; rd_i = 32'hFFFF_FFFF;
        tick();
        we_i = 1'b0;
        #1;
        check("x0_rs2", rs2_o, 32'h0);
        check("x0_rs1_x31", rs1_o, 32'hFFFF_FFFF);

        // Write disabled
        we_i = 1'b0; rd_addr_i = 5'd5; rd_i = 32'hDEAD_BEEF;
        repeat (3) tick();
        rs2_addr_i = 5'd5;
        #1;
        check("we0_rs2", rs2_o, 32'h0);
        check("we0_rs1_x31", rs1_o, 32'hFFFF_FFFF);

        // Async reset between edges
        rs1_addr_i = 5'd31;
        tick();
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_rs1", rs1_o, 32'h0);
        rst_i = 1'b0;
        #1;
        check("async_rst_hold", rs1_o, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            we_i       = ($urandom_range(0, 3) != 0);
            rd_addr_i  = AW'($urandom_range(0, NR - 1));
            rd_i       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
            rs1_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : AW'($urandom_range(0, NR - 1));
            rs2_addr_i = ($urandom_range(0, 7) == 0) ? rs1_addr_i : AW'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 149) == 0) begin
                #1;
                rst_i = 1'b1;
                #1;
                check("rand_rst_rs1", rs1_o, 32'h0);
                check("rand_rst_rs2", rs2_o, 32'h0);
                rst_i = 1'b0;
            end
        end

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
